// File: rtl/instr_enc_if.sv
// Host request/response and SPI byte-engine signals of the instruction encoder.
// slave: the encoder's view; master: the host plus SPI byte engine driving it.
interface instr_enc_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic       req_high;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       cs_n;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_byte;
  logic       rx_done;
  logic [7:0] rx_byte;

  modport slave (
    input  req_valid, req_write, req_high, req_addr, req_wdata, tx_ready, rx_done, rx_byte,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, cs_n, tx_valid, tx_byte
  );

  modport master (
    output req_valid, req_write, req_high, req_addr, req_wdata, tx_ready, rx_done, rx_byte,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, cs_n, tx_valid, tx_byte
  );
endinterface

// File: rtl/instr_enc.sv
// Register request -> framed two-byte SPI burst (setup byte, then data or dummy byte).
// Optional watchdog abort when INSTR_ENC_TIMEOUT_EN is defined.
module instr_enc #(
  parameter logic [7:0] DUMMY_BYTE = 8'h00,
  parameter int         GAP_CYCLES = 2,
  parameter int         TIMEOUT    = 255
) (
  input logic        clk,
  input logic        rst_n,
  instr_enc_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SETUP, SETUP_WAIT, DATA, DATA_WAIT, GAP} state_t;
  typedef struct packed {
    logic       write;
    logic [7:0] wdata;
  } req_t;

  state_t     state;
  req_t       req;
  logic [3:0] gap_cnt;

  logic       accept, byte_done, gap_done, wd_fire;
  logic [7:0] data_byte;

  assign accept    = (state == IDLE) && bus.req_valid && bus.req_ready;
  assign data_byte = req.write ? req.wdata : DUMMY_BYTE;
  assign gap_done  = (state == GAP) && (gap_cnt == 4'(GAP_CYCLES - 1));
  // Last byte finishes either after its handshake or in the same cycle (zero-latency master).
  assign byte_done = ((state == DATA) && bus.tx_ready && bus.rx_done) ||
                     ((state == DATA_WAIT) && bus.rx_done);

`ifdef INSTR_ENC_TIMEOUT_EN
  logic [7:0] wdog;
  logic       active, advance;

  assign active  = (state == SETUP) || (state == SETUP_WAIT) ||
                   (state == DATA)  || (state == DATA_WAIT);
  assign advance = accept || gap_done ||
                   (((state == SETUP) || (state == DATA)) && bus.tx_ready) ||
                   (((state == SETUP_WAIT) || (state == DATA_WAIT)) && bus.rx_done);
  assign wd_fire = active && !advance && (wdog == 8'(TIMEOUT - 1));

  // Cleared on every state transition, so it measures time spent in the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wdog <= '0;
    else if (advance || !active) wdog <= '0;
    else                        wdog <= wdog + 8'd1;
  end
`else
  // No watchdog: TIMEOUT is only legal in 1..255, so this is constant 0.
  assign wd_fire = (TIMEOUT < 1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req           <= '0;
      gap_cnt       <= '0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 8'h00;
      bus.rsp_err   <= 1'b0;
      bus.cs_n      <= 1'b1;
      bus.tx_valid  <= 1'b0;
      bus.tx_byte   <= 8'h00;
    end else begin
      bus.rsp_valid <= 1'b0;
      if (wd_fire) begin
        bus.tx_valid  <= 1'b0;
        bus.cs_n      <= 1'b1;
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= 1'b1;
        bus.rsp_rdata <= 8'h00;
        gap_cnt       <= '0;
        state         <= GAP;
      end else if (byte_done) begin
        bus.tx_valid  <= 1'b0;
        bus.cs_n      <= 1'b1;
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= 1'b0;
        bus.rsp_rdata <= req.write ? 8'h00 : bus.rx_byte;
        gap_cnt       <= '0;
        state         <= GAP;
      end else begin
        case (state)
          IDLE: if (accept) begin
            req           <= '{write: bus.req_write, wdata: bus.req_wdata};
            bus.req_ready <= 1'b0;
            bus.cs_n      <= 1'b0;
            bus.tx_byte   <= {bus.req_write, bus.req_high, bus.req_addr};
            bus.tx_valid  <= 1'b1;
            state         <= SETUP;
          end
          SETUP: if (bus.tx_ready) begin
            if (bus.rx_done) begin
              // Setup byte taken and finished at once: go straight to the data byte.
              bus.tx_byte <= data_byte;
              state       <= DATA;
            end else begin
              bus.tx_valid <= 1'b0;
              state        <= SETUP_WAIT;
            end
          end
          SETUP_WAIT: if (bus.rx_done) begin
            bus.tx_byte  <= data_byte;
            bus.tx_valid <= 1'b1;
            state        <= DATA;
          end
          DATA: if (bus.tx_ready) begin
            bus.tx_valid <= 1'b0;
            state        <= DATA_WAIT;
          end
          DATA_WAIT: begin
          end
          GAP: if (gap_done) begin
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instr_enc.sv
// Directed bench for instr_enc: scoreboard of expected tx bytes and responses, plus a
// byte-engine model that returns rx_done a programmable number of cycles after each handshake.
module tb_instr_enc;
  localparam int         GAP   = 2;
  localparam int         TO    = 20;
  localparam logic [7:0] DUMMY = 8'h00;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_enc_if bus ();
  instr_enc #(.DUMMY_BYTE(DUMMY), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_tx[$];
  logic [8:0] exp_rsp[$];
  logic [7:0] miso[$];
  int  lat = 8;
  bit  drop_rx = 0;
  int  hs_count = 0, rsp_count = 0, rsp_cyc = 0, acc_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pop_miso();
    if (miso.size() == 0) return 8'h00;
    return miso.pop_front();
  endfunction

  // Byte engine model and output monitor
  initial begin
    logic [8:0] e;
    logic       hs, prev_vld, prev_hs;
    logic [7:0] prev_byte;
    int         cnt, gap_n;
    bit         gap_on;
    prev_vld = 0; prev_hs = 0; prev_byte = 0; cnt = 0; gap_n = 0; gap_on = 0;
    bus.rx_done = 1'b0;
    bus.rx_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        rsp_count++;
        rsp_cyc = cyc;
        if (exp_rsp.size() == 0) chk("rsp_extra", 1, 0);
        else begin
          e = exp_rsp.pop_front();
          chk("rsp_err", bus.rsp_err, e[8]);
          chk("rsp_rdata", bus.rsp_rdata, e[7:0]);
        end
        gap_on = 1; gap_n = 0;
      end
      if (gap_on) begin
        if (bus.req_ready) begin chk("gap_len", gap_n, GAP); gap_on = 0; end
        else if (bus.cs_n) gap_n++;
        else begin chk("gap_cs", bus.cs_n, 1); gap_on = 0; end
      end
      if (!bus.cs_n) chk("ready_busy", bus.req_ready, 0);
      if (bus.tx_valid && prev_vld && !prev_hs) chk("tx_hold", bus.tx_byte, prev_byte);
      hs = bus.tx_valid && bus.tx_ready;
      if (hs) begin
        hs_count++;
        chk("hs_cs", bus.cs_n, 0);
        if (exp_tx.size() == 0) chk("tx_extra", 1, 0);
        else chk("tx_byte", bus.tx_byte, exp_tx.pop_front());
        if (!drop_rx) begin
          if (lat == 0) begin bus.rx_done = 1'b1; bus.rx_byte = pop_miso(); end
          else cnt = lat;
        end
      end
      prev_vld = bus.tx_valid; prev_hs = hs; prev_byte = bus.tx_byte;
      @(posedge clk); #1;
      bus.rx_done = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin bus.rx_done = 1'b1; bus.rx_byte = pop_miso(); end
      end
    end
  end

  task automatic issue(input logic wr, input logic hi, input logic [5:0] a,
                       input logic [7:0] wd, input bit hold);
    bit ok = 0;
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_high = hi;
    bus.req_addr = a; bus.req_wdata = wd;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    acc_cyc = cyc + 1;
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  // rd: byte the slave returns during the data slot
  task automatic req(input logic wr, input logic hi, input logic [5:0] a,
                     input logic [7:0] wd, input logic [7:0] rd, input bit hold);
    exp_tx.push_back({wr, hi, a});
    exp_tx.push_back(wr ? wd : DUMMY);
    miso.push_back(8'hE7);
    miso.push_back(rd);
    exp_rsp.push_back({1'b0, wr ? 8'h00 : rd});
    issue(wr, hi, a, wd, hold);
  endtask

  task automatic wait_rsp(input int n);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (rsp_count >= n) begin ok = 1; break; end
    end
    if (!ok) chk("rsp_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int base;
    bit ok;
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "bench watchdog");
  end

  initial begin
    int base;
    bit ok;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_high = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rdata", bus.rsp_rdata, 0);
    chk("rst_err", bus.rsp_err, 0);
    chk("rst_cs_n", bus.cs_n, 1);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_byte", bus.tx_byte, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Write 0x05 <- 0xA5: bytes 0x85, 0xA5
    req(1'b1, 1'b0, 6'h05, 8'hA5, 8'h00, 0);
    wait_rsp(1);
    chk("lat_write", rsp_cyc - acc_cyc, 2 + 2 * 8);
    wait_idle();

    // Read high=1 addr 0x02: bytes 0x42, dummy; slave returns 0x3C
    req(1'b0, 1'b1, 6'h02, 8'h00, 8'h3C, 0);
    wait_rsp(2);
    chk("lat_read", rsp_cyc - acc_cyc, 18);
    wait_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rdata_hold", bus.rsp_rdata, 8'h3C);
    @(posedge clk); #1;

    // Back-to-back with req_valid held
    req(1'b0, 1'b0, 6'h3F, 8'h00, 8'h96, 1);
    req(1'b1, 1'b1, 6'h11, 8'h5E, 8'h00, 0);
    wait_rsp(4);
    wait_idle();

    // Backpressure on both bytes
    bus.tx_ready = 1'b0;
    req(1'b1, 1'b1, 6'h2A, 8'h5A, 8'h00, 0);
    for (int b = 0; b < 2; b++) begin
      ok = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (bus.tx_valid) begin ok = 1; break; end
      end
      if (!ok) chk("stall_timeout", 0, 1);
      base = hs_count;
      repeat (5) @(posedge clk); #1;
      bus.tx_ready = 1'b1;
      for (int i = 0; i < 20 && hs_count == base; i++) @(posedge clk);
      #1;
      if (b == 0) bus.tx_ready = 1'b0;
    end
    chk("stall_hs", hs_count - base, 1);
    wait_rsp(5);
    wait_idle();

    // Zero-latency master: rx_done together with tx_ready
    lat = 0;
    req(1'b0, 1'b0, 6'h00, 8'h00, 8'hC3, 0);
    wait_rsp(6);
    chk("lat_zero", rsp_cyc - acc_cyc, 2);
    wait_idle();
    lat = 8;

    // Reset while waiting for the data byte to finish
    base = hs_count;
    req(1'b1, 1'b0, 6'h0A, 8'h77, 8'h00, 0);
    for (int i = 0; i < 50 && hs_count < base + 2; i++) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_cs_n", bus.cs_n, 1);
    chk("mid_rst_tx_valid", bus.tx_valid, 0);
    chk("mid_rst_ready", bus.req_ready, 1);
    chk("mid_rst_rsp", bus.rsp_valid, 0);
    chk("mid_rst_tx_left", exp_tx.size(), 0);
    exp_rsp.delete();
    miso.delete();
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    chk("mid_rst_no_rsp", rsp_count, 6);
    #1;

    // Recovery after reset
    req(1'b1, 1'b0, 6'h15, 8'h00, 8'h00, 0);
    wait_rsp(7);
    wait_idle();

`ifdef INSTR_ENC_TIMEOUT_EN
    drop_rx = 1;
    exp_tx.push_back({1'b0, 1'b1, 6'h07});
    exp_rsp.push_back({1'b1, 8'h00});
    issue(1'b0, 1'b1, 6'h07, 8'h00, 0);
    wait_rsp(8);
    chk("lat_timeout", rsp_cyc - acc_cyc, 1 + TO);
    wait_idle();
    drop_rx = 0;
    req(1'b0, 1'b0, 6'h09, 8'h00, 8'h81, 0);
    wait_rsp(9);
    wait_idle();
`endif

    repeat (4) @(posedge clk);
    chk("tx_left", exp_tx.size(), 0);
    chk("rsp_left", exp_rsp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
